data_mem_responder: RTL and testbench

- Memory-side responder for the req/gnt/r_valid data-memory protocol that the CPU control unit drives.
- Holds a word-addressed RAM with byte enables and accepts one transaction at a time.
- Inserts a configurable grant wait and response latency so the core's handshake state machine can be exercised against realistic memory timing.
- Sits between the datapath's data-memory port and the on-chip data RAM.

---
 rtl/data_mem_responder_if.sv | 50 +++++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core's load/store unit and the memory
// responder. req/gnt handshake carries one request; r_valid returns the
// matching response one or more cycles later.
//
//   data_req           core -> mem   request, held until granted
//   data_gnt           mem  -> core  request accepted this cycle
//   data_addr          core -> mem   byte address
//   data_write_enable  core -> mem   0 = read, 1 = write
//   data_be            core -> mem   byte enables for writes
//   data_wdata         core -> mem   write data
//   data_r_valid       mem  -> core  one-cycle response strobe
//   data_rdata         mem  -> core  read data, valid with data_r_valid
//   data_err           mem  -> core  error flag, valid with data_r_valid
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req;
    logic                  data_gnt;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic                  data_write_enable;
    logic [3:0]            data_be;
    logic [31:0]           data_wdata;
    logic                  data_r_valid;
    logic [31:0]           data_rdata;
    logic                  data_err;

    modport master (
        output data_req,
        input  data_gnt,
        output data_addr,
        output data_write_enable,
        output data_be,
        output data_wdata,
        input  data_r_valid,
        input  data_rdata,
        input  data_err
    );

    modport slave (
        input  data_req,
        output data_gnt,
        input  data_addr,
        input  data_write_enable,
        input  data_be,
        input  data_wdata,
        output data_r_valid,
        output data_rdata,
        output data_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's req/gnt/r_valid data-memory port.
// Holds a word-addressed RAM with byte enables, accepts one transaction at
// a time and inserts a configurable grant wait (GNT_WAIT) and response
// latency (RSP_LAT) so the core's handshake FSM sees realistic timing.
//
//   CLK    rising-edge clock
//   RES_N  asynchronous active-low reset (RAM contents are not reset)
//   mem    slave side of data_mem_responder_if (req/gnt request channel,
//          r_valid/rdata/err response channel)
module data_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int GNT_WAIT   = 0,
    parameter int RSP_LAT    = 1
) (
    input  logic                   CLK,
    input  logic                   RES_N,
    data_mem_responder_if.slave    mem
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_WAIT,
        RESP_WAIT
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [3:0]       lat_cnt;
    logic [31:0]      ram [DEPTH];

    // Response captured at the accept edge, presented at the strobe
    logic [31:0]      resp_data;
    logic             resp_err;

    logic             r_valid_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             gnt;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             addr_err;
    logic [31:0]      acc_data;

    assign idx = mem.data_addr[IDX_W+1:2];

    // Anything at or above DEPTH*4 has a non-zero bit above the word index
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_range
            assign out_of_range = |mem.data_addr[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign addr_err = (|mem.data_addr[1:0]) | out_of_range;

    // Writes and faulting accesses report zero data
    assign acc_data = (addr_err || mem.data_write_enable) ? 32'h0 : ram[idx];

    // Grant is combinational so a zero-wait responder grants in the req cycle;
    // gating with RES_N keeps gnt low during reset whatever req does.
    always_comb begin
        gnt = 1'b0;
        if (RES_N && mem.data_req) begin
            case (state)
                IDLE:       gnt = (GNT_WAIT == 0);
                GRANT_WAIT: gnt = (wait_cnt == 4'd1);
                default:    gnt = 1'b0;
            endcase
        end
    end

    // Byte-enabled write lands at the accept edge, so a following read sees it
    always_ff @(posedge CLK) begin
        if (gnt && mem.data_write_enable && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.data_be[b]) begin
                    ram[idx][8*b +: 8] <= mem.data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Handshake FSM. lat_cnt counts down from RSP_LAT; the strobe cycle is the
    // one in which lat_cnt reads 1, so r_valid is registered one edge earlier
    // (at the accept edge itself when RSP_LAT is 1). The FSM stays in
    // RESP_WAIT through the strobe cycle, which blocks a grant until the cycle
    // after r_valid.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_cnt   <= 4'd0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
            r_valid_q <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= 1'b0;
            if (gnt) begin
                state     <= RESP_WAIT;
                wait_cnt  <= 4'd0;
                lat_cnt   <= 4'(RSP_LAT);
                resp_data <= acc_data;
                resp_err  <= addr_err;
                if (RSP_LAT == 1) begin
                    r_valid_q <= 1'b1;
                    rdata_q   <= acc_data;
                    err_q     <= addr_err;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (mem.data_req && (GNT_WAIT != 0)) begin
                            wait_cnt <= 4'(GNT_WAIT);
                            state    <= GRANT_WAIT;
                        end
                    end
                    GRANT_WAIT: begin
                        if (!mem.data_req) begin
                            // Request withdrawn: abandon without any access
                            wait_cnt <= 4'd0;
                            state    <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    RESP_WAIT: begin
                        lat_cnt <= lat_cnt - 4'd1;
                        if (lat_cnt == 4'd2) begin
                            r_valid_q <= 1'b1;
                            rdata_q   <= resp_data;
                            err_q     <= resp_err;
                        end
                        if (lat_cnt == 4'd1) begin
                            lat_cnt <= 4'd0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mem.data_gnt     = gnt;
    assign mem.data_r_valid = r_valid_q;
    assign mem.data_rdata   = rdata_q;
    assign mem.data_err     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Three instances with different timing:
//   0: GNT_WAIT=0, RSP_LAT=1   (table-driven functional vectors)
//   1: GNT_WAIT=3, RSP_LAT=2   (grant wait, back-to-back held request)
//   2: GNT_WAIT=2, RSP_LAT=4   (withdrawn request, reset mid-transaction)
// Expected responses are queued when a request is driven and compared
// when the matching r_valid appears.
module tb_data_mem_responder;

    logic CLK = 1'b0;
    logic RES_N = 1'b0;

    always #5 CLK = ~CLK;

    logic        req_d    [3];
    logic        we_d     [3];
    logic [31:0] addr_d   [3];
    logic [3:0]  be_d     [3];
    logic [31:0] wdata_d  [3];
    logic        gnt_m    [3];
    logic        rvalid_m [3];
    logic [31:0] rdata_m  [3];
    logic        err_m    [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : u
            localparam int GW = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
            localparam int RL = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

            data_mem_responder_if #(.ADDR_WIDTH(32)) bus ();

            assign bus.data_req          = req_d[g];
            assign bus.data_write_enable = we_d[g];
            assign bus.data_addr         = addr_d[g];
            assign bus.data_be           = be_d[g];
            assign bus.data_wdata        = wdata_d[g];
            assign gnt_m[g]              = bus.data_gnt;
            assign rvalid_m[g]           = bus.data_r_valid;
            assign rdata_m[g]            = bus.data_rdata;
            assign err_m[g]              = bus.data_err;

            data_mem_responder #(
                .ADDR_WIDTH(32),
                .DEPTH     (1024),
                .GNT_WAIT  (GW),
                .RSP_LAT   (RL)
            ) dut (
                .CLK  (CLK),
                .RES_N(RES_N),
                .mem  (bus.slave)
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        int          inst;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sbq[$];
    exp_t got;
    logic prev_rv [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (rvalid_m[i]) begin
                chk($sformatf("rvalid_single_%0d", i), {31'b0, prev_rv[i]}, 32'h0);
                if (sbq.size() == 0) begin
                    chk($sformatf("rvalid_unexpected_%0d", i), {31'b0, rvalid_m[i]}, 32'h0);
                end else begin
                    got = sbq.pop_front();
                    chk($sformatf("rsp_inst_%0d", i), i, got.inst);
                    chk($sformatf("rsp_rdata_%0d", i), rdata_m[i], got.d);
                    chk($sformatf("rsp_err_%0d", i), {31'b0, err_m[i]}, {31'b0, got.e});
                end
            end
            prev_rv[i] <= rvalid_m[i];
        end
    end

    task automatic drive(input int i, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        req_d[i]   = 1'b1;
        we_d[i]    = we;
        addr_d[i]  = a;
        be_d[i]    = be;
        wdata_d[i] = wd;
    endtask

    task automatic release_bus(input int i);
        req_d[i]   = 1'b0;
        we_d[i]    = 1'($urandom);
        addr_d[i]  = $urandom;
        be_d[i]    = 4'($urandom);
        wdata_d[i] = $urandom;
    endtask

    // Returns the number of cycles from request to grant (bounded)
    task automatic wait_gnt(input int i, output int n);
        n = 0;
        #1;
        while (!gnt_m[i] && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic run_txn(input int i, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] exp_d, input logic exp_e,
                           input int exp_gw, input int exp_lat, input string tag);
        int n;
        int m;
        @(negedge CLK);
        drive(i, we, a, be, wd);
        sbq.push_back('{i, exp_d, exp_e});
        wait_gnt(i, n);
        chk({tag, "_gnt_delay"}, n, exp_gw);
        @(negedge CLK);
        release_bus(i);
        m = 1;
        while (!rvalid_m[i] && m < 40) begin
            @(negedge CLK);
            m++;
        end
        chk({tag, "_rsp_lat"}, m, exp_lat);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int g1, g2, rv1, ngnt, nrv;

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0012, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0011, 4'hF, 32'hAAAA_5555, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0FFC, 4'h2, 32'h0000_AB00, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0FFC, 4'h0, 32'h0000_0000, 32'h1234_AB78, 1'b0};
        vecs[15] = '{1'b0, 32'h2000_0010, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};

        for (int i = 0; i < 3; i++) begin
            req_d[i]   = 1'b0;
            we_d[i]    = 1'b0;
            addr_d[i]  = 32'h0;
            be_d[i]    = 4'h0;
            wdata_d[i] = 32'h0;
        end

        // Reset state; a request during reset must not be granted
        req_d[0] = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_gnt_forced_low", {31'b0, gnt_m[0]}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rvalid_%0d", i), {31'b0, rvalid_m[i]}, 32'h0);
            chk($sformatf("reset_rdata_%0d", i), rdata_m[i], 32'h0);
            chk($sformatf("reset_err_%0d", i), {31'b0, err_m[i]}, 32'h0);
        end
        req_d[0] = 1'b0;
        @(negedge CLK);
        RES_N = 1'b1;

        // Instance 0: zero grant wait, single-cycle latency
        for (int v = 0; v < 16; v++) begin
            run_txn(0, vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata,
                    vecs[v].exp_d, vecs[v].exp_e, 0, 1, $sformatf("vec%0d", v));
        end

        // Instance 1: grant wait 3, latency 2, then a continuously held request
        run_txn(1, 1'b1, 32'h40, 4'hF, 32'h5A5A_1234, 32'h0, 1'b0, 3, 2, "b_write");
        @(negedge CLK);
        drive(1, 1'b0, 32'h40, 4'h0, 32'h0);
        sbq.push_back('{1, 32'h5A5A_1234, 1'b0});
        sbq.push_back('{1, 32'h5A5A_1234, 1'b0});
        g1 = -1; g2 = -1; rv1 = -1; ngnt = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (gnt_m[1]) begin
                ngnt++;
                if (g1 < 0) g1 = c;
                else if (g2 < 0) g2 = c;
            end
            if (rvalid_m[1] && rv1 < 0) rv1 = c;
            @(negedge CLK);
        end
        release_bus(1);
        chk("held_first_gnt", g1, 3);
        chk("held_first_rvalid", rv1, 5);
        chk("held_second_gnt", g2, 9);
        chk("held_gnt_count", ngnt, 2);

        // Instance 2: request withdrawn during the grant wait
        @(negedge CLK);
        drive(2, 1'b0, 32'h8, 4'h0, 32'h0);
        ngnt = 0; nrv = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (gnt_m[2]) ngnt++;
            if (rvalid_m[2]) nrv++;
            @(negedge CLK);
            release_bus(2);
        end
        chk("withdrawn_gnt_count", ngnt, 0);
        chk("withdrawn_rvalid_count", nrv, 0);
        run_txn(2, 1'b1, 32'h8, 4'hF, 32'h0102_0304, 32'h0, 1'b0, 2, 4, "c_write8");
        run_txn(2, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0102_0304, 1'b0, 2, 4, "c_read8");
        run_txn(2, 1'b1, 32'h30, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 4, "c_write30");
        run_txn(2, 1'b0, 32'h30, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 4, "c_read30");

        // Reset between accept and response: no strobe, outputs cleared
        @(negedge CLK);
        drive(2, 1'b1, 32'h34, 4'hF, 32'h600D_CAFE);
        wait_gnt(2, n);
        chk("rst_txn_gnt_delay", n, 2);
        @(negedge CLK);
        release_bus(2);
        @(negedge CLK);
        RES_N = 1'b0;
        #1;
        chk("midrst_rvalid", {31'b0, rvalid_m[2]}, 32'h0);
        chk("midrst_rdata", rdata_m[2], 32'h0);
        chk("midrst_err", {31'b0, err_m[2]}, 32'h0);
        @(negedge CLK);
        RES_N = 1'b1;
        nrv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (rvalid_m[2]) nrv++;
        end
        chk("postrst_rvalid_count", nrv, 0);
        chk("postrst_rdata", rdata_m[2], 32'h0);
        run_txn(2, 1'b0, 32'h34, 4'h0, 32'h0, 32'h600D_CAFE, 1'b0, 2, 4, "c_read34");

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", sbq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
